serial_rx_fifo: RTL

UART receiver front-end with an 8-entry receive FIFO. It sits directly upstream of the keyboard controller and turns the raw serial line into bytes, for example ASCII '1'..'4' (0x31..0x34) used for frame select. The keyboard controller drains it with a valid/pop handshake. Framing and overrun faults are reported through sticky flags.

---
 rtl/serial_rx_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Framing and overrun faults are reported through sticky flags.
module serial_rx_fifo #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      IN_SERIAL_RX,
    output logic [7:0]                OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      IN_POP,
    output logic [FIFO_ADDR_BITS:0]   OUT_COUNT,
    output logic                      OUT_OVERRUN,
    output logic                      OUT_FRAME_ERR,
    input  logic                      IN_CLEAR_ERR
);

    // Handshake: OUT_DATA is the head byte whenever OUT_VALID=1. A pop happens
    // on a clock edge where IN_POP=1 and OUT_VALID=1; IN_POP while empty is ignored.

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_BITS:0] FULL_COUNT = (FIFO_ADDR_BITS + 1)'(DEPTH);

    // Explicit encoding so the state can be observed by number.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                     state;
    logic                       rx_meta;
    logic                       rx_s;
    logic [CW-1:0]              baud_cnt;
    logic [2:0]                 bit_idx;
    logic [7:0]                 shift;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0]  wr_ptr;
    logic [FIFO_ADDR_BITS-1:0]  rd_ptr;
    logic [FIFO_ADDR_BITS:0]    count;

    logic                       stop_sample;
    logic                       push;
    logic                       frame_set;
    logic                       pop;
    logic                       full;
    logic                       do_push;
    logic                       overrun_set;

    // Two-flop synchronizer; resets to the idle level so no edge is fabricated.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= IN_SERIAL_RX;
            rx_s    <= rx_meta;
        end
    end

    // Stop-bit decisions feed the FIFO and error flags on the same edge.
    always_comb begin
        stop_sample = (state == STOP) && (baud_cnt == FULL_M1);
        push        = stop_sample && rx_s;
        frame_set   = stop_sample && !rx_s;
        pop         = IN_POP && (count != '0);
        full        = (count == FULL_COUNT);
        do_push     = push && (!full || pop);
        overrun_set = push && full && !pop;
    end

    // Receive FSM: start qualification at half a bit, then full-bit sampling.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge CLK) begin
        if (!RESET && do_push) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a new error on the clearing cycle keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_OVERRUN   <= 1'b0;
            OUT_FRAME_ERR <= 1'b0;
        end else begin
            OUT_OVERRUN   <= overrun_set | (OUT_OVERRUN & ~IN_CLEAR_ERR);
            OUT_FRAME_ERR <= frame_set | (OUT_FRAME_ERR & ~IN_CLEAR_ERR);
        end
    end

    assign OUT_VALID = (count != '0);
    assign OUT_COUNT = count;
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : 8'h00;

endmodule
